// File: rtl/shot_sequencer_pkg.sv
// Shared types and playfield geometry for the shot sequencer.
// Pixel constants are truncated to the 10-bit ball coordinate width.
package shot_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_AIM       = 3'd1,
    ST_LAUNCH    = 3'd2,
    ST_FLIGHT    = 3'd3,
    ST_MADE      = 3'd4,
    ST_MISS      = 3'd5,
    ST_VIOLATION = 3'd6,
    ST_HOLD      = 3'd7
  } state_t;

  localparam int PIX_W      = 10;
  localparam int HOOP_X_MIN = 540;
  localparam int HOOP_X_MAX = 580;
  localparam int HOOP_Y     = 120;
  localparam int FLOOR_Y    = 470;
  localparam int X_LIMIT    = 639;

  localparam int SHOT_SECS  = 24;
  localparam int SCORE_W    = 7;
  localparam int SCORE_MAX  = 99;

  // The score display only has two digits, so the count pins at SCORE_MAX.
  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    return (s >= SCORE_W'(SCORE_MAX)) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/shot_sequencer_if.sv
// Bundle between the sequencer, the kinematic block, the accelerometer and the displays.
// master is the sequencer side; slave is the surrounding top level.
interface shot_sequencer_if;

  logic signed [15:0] accel_x;
  logic signed [15:0] accel_y;
  logic        [9:0]  ball_x;
  logic        [9:0]  ball_y;
  logic               kin_rst;
  logic               kin_go;
  logic signed [15:0] aim_x;
  logic signed [15:0] aim_y;
  logic        [4:0]  shot_clock;
  logic        [6:0]  score;
  logic               made;
  logic        [2:0]  state;

  modport master (
    input  accel_x, accel_y, ball_x, ball_y,
    output kin_rst, kin_go, aim_x, aim_y, shot_clock, score, made, state
  );

  modport slave (
    output accel_x, accel_y, ball_x, ball_y,
    input  kin_rst, kin_go, aim_x, aim_y, shot_clock, score, made, state
  );

endinterface

// File: rtl/shot_sequencer_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a one-cycle
// pulse when the accepted level goes high. Shared with the other board buttons.
module btn_debounce #(
  parameter int STABLE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // The accepted level only flips after STABLE_CYC consecutive disagreeing samples;
  // press fires on the same edge the level rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
        press <= sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/shot_sequencer.sv
// Game controller for one shot: aim, launch the kinematic block, judge make/miss,
// and run the shot clock and score for the displays.
module shot_sequencer
  import shot_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int HOLD_CYC     = 50_000_000
) (
  input  logic              CLK100MHZ,
  input  logic              rst,
  input  logic              btn_shoot,
  shot_sequencer_if.master  bus
);

  localparam int TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_HZ - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

  localparam logic [PIX_W-1:0] X_MIN     = PIX_W'(HOOP_X_MIN);
  localparam logic [PIX_W-1:0] X_MAX     = PIX_W'(HOOP_X_MAX);
  localparam logic [PIX_W-1:0] RIM_Y     = PIX_W'(HOOP_Y);
  localparam logic [PIX_W-1:0] FLOOR_PIX = PIX_W'(FLOOR_Y);
  localparam logic [PIX_W-1:0] X_EDGE    = PIX_W'(X_LIMIT);
  localparam logic [4:0]       SHOT_LOAD = 5'(SHOT_SECS);

  state_t            st;
  state_t            nxt;
  logic              press;
  logic              tick;
  logic              hold_done;
  logic              make_hit;
  logic              miss_hit;
  logic [TICK_W-1:0] tick_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [PIX_W-1:0]  prev_y;

  btn_debounce #(
    .STABLE_CYC (DEBOUNCE_CYC)
  ) u_debounce (
    .clk     (CLK100MHZ),
    .rst     (rst),
    .btn_raw (btn_shoot),
    .press   (press)
  );

  assign tick      = (st == ST_AIM)  && (tick_cnt == TICK_LAST);
  assign hold_done = (st == ST_HOLD) && (hold_cnt == HOLD_LAST);

  // Only a downward pass through the rim line counts; prev_y is last cycle's row.
  assign make_hit = (bus.ball_x >= X_MIN) && (bus.ball_x <= X_MAX) &&
                    (prev_y < RIM_Y) && (bus.ball_y >= RIM_Y);
  assign miss_hit = (bus.ball_y >= FLOOR_PIX) || (bus.ball_x >= X_EDGE);

  always_comb begin
    nxt = st;
    unique case (st)
      ST_IDLE:   if (press) nxt = ST_AIM;
      ST_AIM: begin
        if (tick && (bus.shot_clock == 5'd1)) nxt = ST_VIOLATION;
        else if (press)                       nxt = ST_LAUNCH;
      end
      ST_LAUNCH: nxt = ST_FLIGHT;
      ST_FLIGHT: begin
        if (make_hit)      nxt = ST_MADE;
        else if (miss_hit) nxt = ST_MISS;
      end
      ST_MADE, ST_MISS, ST_VIOLATION: nxt = ST_HOLD;
      ST_HOLD:   if (hold_done) nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      st             <= ST_IDLE;
      bus.kin_rst    <= 1'b1;
      bus.kin_go     <= 1'b0;
      bus.aim_x      <= '0;
      bus.aim_y      <= '0;
      bus.shot_clock <= SHOT_LOAD;
      bus.score      <= '0;
      bus.made       <= 1'b0;
      tick_cnt       <= '0;
      hold_cnt       <= '0;
      prev_y         <= '0;
    end else begin
      st          <= nxt;
      bus.kin_rst <= (nxt == ST_IDLE) || (nxt == ST_AIM);
      bus.kin_go  <= (nxt == ST_LAUNCH) || (nxt == ST_FLIGHT);
      bus.made    <= (nxt == ST_MADE);

      if (nxt == ST_MADE) bus.score <= score_inc(bus.score);

      if (st == ST_AIM) begin
        bus.aim_x <= bus.accel_x;
        bus.aim_y <= bus.accel_y;
      end

      // Held at zero outside AIM so every shot starts with a full first second.
      tick_cnt <= (st == ST_AIM && !tick) ? tick_cnt + TICK_W'(1) : '0;
      hold_cnt <= (st == ST_HOLD) ? hold_cnt + HOLD_W'(1) : '0;

      if (nxt == ST_IDLE) bus.shot_clock <= SHOT_LOAD;
      else if (tick)      bus.shot_clock <= bus.shot_clock - 5'd1;

      if (st == ST_LAUNCH || st == ST_FLIGHT) prev_y <= bus.ball_y;
    end
  end

  assign bus.state = st;

endmodule

// File: tb/tb_shot_sequencer.sv
// Directed bench for shot_sequencer with a cycle-level behavioural model and
// literal checkpoints at the interesting moments of each shot.
module tb_shot_sequencer;

  localparam int CLK_HZ = 20;
  localparam int DEB    = 4;
  localparam int HOLD   = 8;

  localparam int S_IDLE = 0, S_AIM = 1, S_LAUNCH = 2, S_FLIGHT = 3;
  localparam int S_MADE = 4, S_MISS = 5, S_VIOL = 6, S_HOLD = 7;

  logic clk = 1'b0;
  logic rst;
  logic btn_shoot;

  shot_sequencer_if sif ();

  shot_sequencer #(
    .CLK_HZ       (CLK_HZ),
    .DEBOUNCE_CYC (DEB),
    .HOLD_CYC     (HOLD)
  ) dut (
    .CLK100MHZ (clk),
    .rst       (rst),
    .btn_shoot (btn_shoot),
    .bus       (sif)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  int m_state, m_shot, m_score, m_prev_y, m_aim_cyc, m_hold_cyc, m_run;
  logic signed [15:0] m_aim_x, m_aim_y;
  bit m_db, m_b1, m_b2, m_press;
  bit m_valid = 1'b0;

  // Model: button seen two edges late, accepted after DEB agreeing samples, and the
  // game rules applied to the inputs as they stand at each rising edge.
  always @(posedge clk) begin : model_p
    bit s, p, tick, mk, ms;
    if (rst) begin
      m_state = S_IDLE; m_shot = 24; m_score = 0; m_prev_y = 0;
      m_aim_cyc = 0; m_hold_cyc = 0; m_run = 0;
      m_db = 0; m_b1 = 0; m_b2 = 0; m_press = 0;
      m_aim_x = 0; m_aim_y = 0; m_valid = 1'b1;
    end else begin
      p = m_press;
      s = m_b2; m_b2 = m_b1; m_b1 = btn_shoot;
      m_press = 0;
      if (s != m_db) begin
        m_run++;
        if (m_run == DEB) begin m_db = s; m_run = 0; m_press = s; end
      end else begin
        m_run = 0;
      end
      case (m_state)
        S_IDLE: if (p) begin m_state = S_AIM; m_aim_cyc = 0; end
        S_AIM: begin
          m_aim_x = sif.accel_x; m_aim_y = sif.accel_y;
          tick = (m_aim_cyc % CLK_HZ) == CLK_HZ - 1;
          m_aim_cyc++;
          if (tick) m_shot--;
          if (tick && m_shot == 0) m_state = S_VIOL;
          else if (p)              m_state = S_LAUNCH;
        end
        S_LAUNCH: begin m_prev_y = int'(sif.ball_y); m_state = S_FLIGHT; end
        S_FLIGHT: begin
          mk = sif.ball_x >= 540 && sif.ball_x <= 580 && m_prev_y < 120 && sif.ball_y >= 120;
          ms = sif.ball_y >= 470 || sif.ball_x >= 639;
          m_prev_y = int'(sif.ball_y);
          if (mk) begin m_state = S_MADE; if (m_score < 99) m_score++; end
          else if (ms) m_state = S_MISS;
        end
        S_MADE, S_MISS, S_VIOL: begin m_state = S_HOLD; m_hold_cyc = 0; end
        default: begin
          m_hold_cyc++;
          if (m_hold_cyc == HOLD) begin m_state = S_IDLE; m_shot = 24; end
        end
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pin(input string name, input logic [31:0] dut_v, input logic [31:0] model_v,
                     input logic [31:0] lit);
    checkOutput({name, "_dut"}, dut_v, lit);
    checkOutput({name, "_model"}, model_v, lit);
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("state",      32'(sif.state),      32'(m_state));
      checkOutput("kin_rst",    32'(sif.kin_rst),    32'(m_state == S_IDLE || m_state == S_AIM));
      checkOutput("kin_go",     32'(sif.kin_go),     32'(m_state == S_LAUNCH || m_state == S_FLIGHT));
      checkOutput("made",       32'(sif.made),       32'(m_state == S_MADE));
      checkOutput("aim_x",      32'(sif.aim_x),      32'(m_aim_x));
      checkOutput("aim_y",      32'(sif.aim_y),      32'(m_aim_y));
      checkOutput("shot_clock", 32'(sif.shot_clock), 32'(m_shot));
      checkOutput("score",      32'(sif.score),      32'(m_score));
    end
  end

  task automatic applyStimulus(input logic b, input logic [9:0] bx, input logic [9:0] by, input int n);
    btn_shoot  = b;
    sif.ball_x = bx;
    sif.ball_y = by;
    repeat (n) @(negedge clk);
  endtask

  task automatic waitState(input int s, input int budget, input string name);
    int n = 0;
    while (sif.state !== 3'(s) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_reached"}, 32'(sif.state), 32'(s));
  endtask

  // From IDLE with the button settled low: press into AIM, press again to launch.
  task automatic startShot(input logic [9:0] bx, input logic [9:0] by);
    applyStimulus(1'b1, bx, by, 1);
    waitState(S_AIM, 20, "shot_aim");
    applyStimulus(1'b0, bx, by, 8);
    applyStimulus(1'b1, bx, by, 1);
    waitState(S_FLIGHT, 20, "shot_flight");
    btn_shoot = 1'b0;
  endtask

  task automatic doMake();
    startShot(10'd560, 10'd118);
    applyStimulus(1'b0, 10'd560, 10'd119, 1);
    applyStimulus(1'b0, 10'd560, 10'd120, 1);
    waitState(S_IDLE, 20, "make_idle");
  endtask

  task automatic pinReset(input string tag);
    pin({tag, "_state"},   32'(sif.state),      32'(m_state), 0);
    pin({tag, "_kin_rst"}, 32'(sif.kin_rst),    32'(m_state == S_IDLE || m_state == S_AIM), 1);
    pin({tag, "_kin_go"},  32'(sif.kin_go),     32'(m_state == S_LAUNCH || m_state == S_FLIGHT), 0);
    pin({tag, "_aim_x"},   32'(sif.aim_x),      32'(m_aim_x), 0);
    pin({tag, "_aim_y"},   32'(sif.aim_y),      32'(m_aim_y), 0);
    pin({tag, "_shot"},    32'(sif.shot_clock), 32'(m_shot), 24);
    pin({tag, "_score"},   32'(sif.score),      32'(m_score), 0);
    pin({tag, "_made"},    32'(sif.made),       32'(m_state == S_MADE), 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; btn_shoot = 1'b0;
    sif.accel_x = '0; sif.accel_y = '0; sif.ball_x = '0; sif.ball_y = '0;
    repeat (3) @(negedge clk);
    pinReset("reset");
    rst = 1'b0;

    // Short bounce must not be accepted.
    applyStimulus(1'b1, 10'd0, 10'd0, 2);
    applyStimulus(1'b0, 10'd0, 10'd0, 12);
    pin("bounce_idle", 32'(sif.state), 32'(m_state), S_IDLE);

    // Clean press: AIM appears DEB+3 edges after the button is first sampled high.
    applyStimulus(1'b1, 10'd0, 10'd0, DEB + 2);
    pin("press_early", 32'(sif.state), 32'(m_state), S_IDLE);
    applyStimulus(1'b1, 10'd0, 10'd0, 1);
    pin("press_aim", 32'(sif.state), 32'(m_state), S_AIM);
    pin("aim_kin_rst", 32'(sif.kin_rst), 32'(m_state == S_IDLE || m_state == S_AIM), 1);
    pin("aim_shot", 32'(sif.shot_clock), 32'(m_shot), 24);

    // Aim latch, launch and a make through the rim.
    applyStimulus(1'b0, 10'd560, 10'd118, 8);
    sif.accel_x = 16'sh0100; sif.accel_y = 16'shFF00;
    applyStimulus(1'b1, 10'd560, 10'd118, 1);
    waitState(S_LAUNCH, 20, "launch");
    pin("launch_go", 32'(sif.kin_go), 32'(m_state == S_LAUNCH || m_state == S_FLIGHT), 1);
    pin("launch_aim_x", 32'(sif.aim_x), 32'(m_aim_x), 32'h0100);
    sif.accel_x = 16'sh0000;
    applyStimulus(1'b0, 10'd560, 10'd118, 1);
    pin("flight_state", 32'(sif.state), 32'(m_state), S_FLIGHT);
    pin("flight_aim_x", 32'(sif.aim_x), 32'(m_aim_x), 32'h0100);
    applyStimulus(1'b0, 10'd560, 10'd119, 1);
    applyStimulus(1'b0, 10'd560, 10'd120, 1);
    pin("make_pulse", 32'(sif.made), 32'(m_state == S_MADE), 1);
    applyStimulus(1'b0, 10'd560, 10'd121, 1);
    pin("make_pulse_end", 32'(sif.made), 32'(m_state == S_MADE), 0);
    pin("make_score", 32'(sif.score), 32'(m_score), 1);
    applyStimulus(1'b0, 10'd560, 10'd121, HOLD - 1);
    pin("hold_last", 32'(sif.state), 32'(m_state), S_HOLD);
    applyStimulus(1'b0, 10'd560, 10'd121, 1);
    pin("hold_idle", 32'(sif.state), 32'(m_state), S_IDLE);
    pin("hold_idle_rst", 32'(sif.kin_rst), 32'(m_state == S_IDLE || m_state == S_AIM), 1);

    // Floor miss away from the hoop.
    startShot(10'd300, 10'd400);
    applyStimulus(1'b0, 10'd300, 10'd469, 1);
    applyStimulus(1'b0, 10'd300, 10'd470, 1);
    pin("floor_miss", 32'(sif.state), 32'(m_state), S_MISS);
    pin("floor_score", 32'(sif.score), 32'(m_score), 1);
    waitState(S_IDLE, 20, "miss_idle");

    // Upward crossing is not a make; right edge ends the shot.
    startShot(10'd560, 10'd121);
    applyStimulus(1'b0, 10'd560, 10'd119, 1);
    applyStimulus(1'b0, 10'd560, 10'd118, 1);
    pin("upward_no_make", 32'(sif.state), 32'(m_state), S_FLIGHT);
    applyStimulus(1'b0, 10'd639, 10'd118, 1);
    pin("x_limit_miss", 32'(sif.state), 32'(m_state), S_MISS);
    waitState(S_IDLE, 20, "edge_idle");

    // Make and floor in the same cycle at the right window edge: make wins.
    startShot(10'd580, 10'd119);
    applyStimulus(1'b0, 10'd580, 10'd470, 1);
    pin("make_beats_miss", 32'(sif.state), 32'(m_state), S_MADE);
    waitState(S_IDLE, 20, "both_idle");

    // Just outside the window, then the left window edge.
    startShot(10'd581, 10'd119);
    applyStimulus(1'b0, 10'd581, 10'd125, 1);
    pin("outside_window", 32'(sif.state), 32'(m_state), S_FLIGHT);
    applyStimulus(1'b0, 10'd581, 10'd470, 1);
    waitState(S_IDLE, 20, "outside_idle");
    startShot(10'd540, 10'd119);
    applyStimulus(1'b0, 10'd540, 10'd120, 1);
    pin("left_edge_make", 32'(sif.state), 32'(m_state), S_MADE);
    waitState(S_IDLE, 20, "left_idle");
    pin("score_three", 32'(sif.score), 32'(m_score), 3);

    // Shot clock expiry; a press landing in HOLD is ignored.
    applyStimulus(1'b1, 10'd300, 10'd300, 1);
    waitState(S_AIM, 20, "viol_aim");
    applyStimulus(1'b0, 10'd300, 10'd300, 24 * CLK_HZ - 1);
    pin("viol_pre_state", 32'(sif.state), 32'(m_state), S_AIM);
    pin("viol_pre_shot", 32'(sif.shot_clock), 32'(m_shot), 1);
    applyStimulus(1'b1, 10'd300, 10'd300, 1);
    pin("viol_state", 32'(sif.state), 32'(m_state), S_VIOL);
    pin("viol_shot", 32'(sif.shot_clock), 32'(m_shot), 0);
    applyStimulus(1'b1, 10'd300, 10'd300, 1);
    pin("viol_hold", 32'(sif.state), 32'(m_state), S_HOLD);
    applyStimulus(1'b1, 10'd300, 10'd300, 12);
    pin("hold_press_ignored", 32'(sif.state), 32'(m_state), S_IDLE);
    applyStimulus(1'b0, 10'd300, 10'd300, 8);

    // Press arriving on the final tick loses to the violation.
    applyStimulus(1'b1, 10'd300, 10'd300, 1);
    waitState(S_AIM, 20, "race_aim");
    applyStimulus(1'b0, 10'd300, 10'd300, 24 * CLK_HZ - 7);
    applyStimulus(1'b1, 10'd300, 10'd300, 6);
    pin("race_pre", 32'(sif.state), 32'(m_state), S_AIM);
    applyStimulus(1'b1, 10'd300, 10'd300, 1);
    pin("race_violation", 32'(sif.state), 32'(m_state), S_VIOL);
    applyStimulus(1'b0, 10'd300, 10'd300, 1);
    waitState(S_IDLE, 20, "race_idle");
    applyStimulus(1'b0, 10'd300, 10'd300, 8);

    // Score saturation.
    for (int i = 0; i < 110 && m_score < 99; i++) doMake();
    pin("score_99", 32'(sif.score), 32'(m_score), 99);
    startShot(10'd560, 10'd118);
    applyStimulus(1'b0, 10'd560, 10'd119, 1);
    applyStimulus(1'b0, 10'd560, 10'd120, 1);
    pin("sat_made_pulse", 32'(sif.made), 32'(m_state == S_MADE), 1);
    pin("sat_score", 32'(sif.score), 32'(m_score), 99);
    waitState(S_IDLE, 20, "sat_idle");

    // Reset during FLIGHT.
    sif.accel_x = 16'sh1234; sif.accel_y = 16'sh0F0F;
    startShot(10'd300, 10'd300);
    applyStimulus(1'b0, 10'd300, 10'd301, 1);
    rst = 1'b1;
    applyStimulus(1'b0, 10'd300, 10'd302, 1);
    pinReset("midrst");
    rst = 1'b0;
    applyStimulus(1'b0, 10'd300, 10'd300, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
